// File: rtl/control_execute_unit_pkg.sv
// State codes, opcode/funct constants and ALU op encoding
// shared by the control/execute unit and its ALU.
package control_execute_unit_pkg;

  localparam logic [2:0] STATE_FETCH  = 3'd0;
  localparam logic [2:0] STATE_DECODE = 3'd1;
  localparam logic [2:0] STATE_RF     = 3'd2;
  localparam logic [2:0] STATE_EX     = 3'd3;
  localparam logic [2:0] STATE_WB     = 3'd4;
  localparam logic [2:0] STATE_OUTPUT = 3'd5;
  localparam logic [2:0] STATE_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

endpackage

// File: rtl/control_execute_unit_if.sv
// Instruction fetch request/valid bus between the control unit
// and instruction memory.
interface control_execute_unit_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/control_execute_unit_alu8.sv
// Combinational 8-bit ALU; shifts operate on b by shamt,
// any shift of 8 or more yields zero.
module control_execute_unit_alu8
  import control_execute_unit_pkg::*;
(
  input  alu_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] shamt,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {7'd0, $signed(a) < $signed(b)};
      ALU_SLL: y = (shamt > 5'd7) ? '0 : b << shamt[2:0];
      ALU_SRL: y = (shamt > 5'd7) ? '0 : b >> shamt[2:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/control_execute_unit.sv
// Multi-cycle control/execute unit: fetch, decode, ALU, PC.
// Define SHIFT_OPS_EN to add SLL/SRL support.
module control_execute_unit
  import control_execute_unit_pkg::*;
#(
  parameter int          PC_W        = 8,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_execute_unit_if.master imem,
  output logic [2:0]           state,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic                 instruction_invalid,
  input  logic [7:0]           rsv,
  input  logic [7:0]           rtv,
  output logic [7:0]           result,
  input  logic                 done,
  output logic [PC_W-1:0]      pc
);

  logic        req_q;
  logic [31:0] ir;
  alu_op_t     op_q;
  logic        use_imm_q;

  alu_op_t     dec_op;
  logic        dec_imm;
  logic        dec_inv;
  logic        dec_halt;
  logic [4:0]  dec_rd;
  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [7:0]  alu_b;
  logic [7:0]  alu_y;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  assign opc = ir[31:26];
  assign fn  = ir[5:0];

  always_comb begin
    dec_op   = ALU_ADD;
    dec_imm  = 1'b0;
    dec_inv  = 1'b1;
    dec_halt = 1'b0;
    dec_rd   = ir[15:11];
    unique case (1'b1)
      (opc == OP_RTYPE && fn == FN_ADD): begin
        dec_op  = ALU_ADD;
        dec_inv = 1'b0;
      end
      (opc == OP_RTYPE && fn == FN_SUB): begin
        dec_op  = ALU_SUB;
        dec_inv = 1'b0;
      end
      (opc == OP_RTYPE && fn == FN_AND): begin
        dec_op  = ALU_AND;
        dec_inv = 1'b0;
      end
      (opc == OP_RTYPE && fn == FN_OR): begin
        dec_op  = ALU_OR;
        dec_inv = 1'b0;
      end
      (opc == OP_RTYPE && fn == FN_SLT): begin
        dec_op  = ALU_SLT;
        dec_inv = 1'b0;
      end
`ifdef SHIFT_OPS_EN
      (opc == OP_RTYPE && fn == FN_SLL): begin
        dec_op  = ALU_SLL;
        dec_inv = 1'b0;
      end
      (opc == OP_RTYPE && fn == FN_SRL): begin
        dec_op  = ALU_SRL;
        dec_inv = 1'b0;
      end
`endif
      (opc == OP_ADDI): begin
        dec_op  = ALU_ADD;
        dec_imm = 1'b1;
        dec_inv = 1'b0;
        dec_rd  = ir[20:16];
      end
      (opc == OP_ORI): begin
        dec_op  = ALU_OR;
        dec_imm = 1'b1;
        dec_inv = 1'b0;
        dec_rd  = ir[20:16];
      end
      (opc == HALT_OPCODE): begin
        dec_inv  = 1'b0;
        dec_halt = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate and shamt come straight from the held instruction word
  assign alu_b = use_imm_q ? ir[7:0] : rtv;

  control_execute_unit_alu8 u_alu (
    .op    (op_q),
    .a     (rsv),
    .b     (alu_b),
    .shamt (ir[10:6]),
    .y     (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= STATE_FETCH;
      pc                  <= '0;
      req_q               <= 1'b0;
      ir                  <= '0;
      rs                  <= '0;
      rt                  <= '0;
      rd                  <= '0;
      instruction_invalid <= 1'b0;
      result              <= '0;
      op_q                <= ALU_ADD;
      use_imm_q           <= 1'b0;
    end else begin
      unique case (state)
        STATE_FETCH: begin
          if (req_q && imem.imem_valid) begin
            ir    <= imem.imem_data;
            req_q <= 1'b0;
            state <= STATE_DECODE;
          end else begin
            req_q <= 1'b1;
          end
        end
        STATE_DECODE: begin
          rs                  <= ir[25:21];
          rt                  <= ir[20:16];
          rd                  <= dec_rd;
          instruction_invalid <= dec_inv;
          op_q                <= dec_op;
          use_imm_q           <= dec_imm;
          state <= dec_halt ? STATE_OUTPUT : STATE_RF;
        end
        STATE_RF: state <= STATE_EX;
        STATE_EX: begin
          result <= instruction_invalid ? '0 : alu_y;
          state  <= STATE_WB;
        end
        STATE_WB: begin
          pc    <= pc + PC_W'(1);
          req_q <= 1'b1;
          state <= STATE_FETCH;
        end
        STATE_OUTPUT: begin
          if (done) state <= STATE_HALT;
        end
        STATE_HALT: state <= STATE_HALT;
        default: state <= STATE_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_execute_unit.sv
// Randomized bench for control_execute_unit with a behavioural
// instruction-level reference model and an emulated register file.
module tb_control_execute_unit;
  import control_execute_unit_pkg::*;

`ifdef SHIFT_OPS_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic [4:0] rs, rt, rd;
  logic       instruction_invalid;
  logic [7:0] rsv, rtv, result;
  logic       done;
  logic [7:0] pc;

  control_execute_unit_if #(.PC_W(8)) bus ();

  control_execute_unit #(
    .PC_W        (8),
    .HALT_OPCODE (6'h3F)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .imem                (bus.master),
    .state               (state),
    .rs                  (rs),
    .rt                  (rt),
    .rd                  (rd),
    .instruction_invalid (instruction_invalid),
    .rsv                 (rsv),
    .rtv                 (rtv),
    .result              (result),
    .done                (done),
    .pc                  (pc)
  );

  always #5 clk = ~clk;

  // Emulated register file
  logic [7:0] rf [32];
  assign rsv = rf[rs];
  assign rtv = rf[rt];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h00;
    end else if (state == STATE_WB && rd != 5'd0
                 && !instruction_invalid) begin
      rf[rd] <= result;
    end
  end

  int total = 0;
  int bad   = 0;
  int mdl [32];
  int exp_pc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t,
      input int d, input int sh, input int f);
    rtype = {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(f)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int s,
      input int t, input int imm);
    itype = {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  task automatic model(input logic [31:0] ins,
                       output int erd, output bit einv,
                       output int eres, output bit ehalt);
    int opc, fn, s, t, sh, a, b, imm, sa, sb, r;
    opc = int'(ins[31:26]);
    fn  = int'(ins[5:0]);
    s   = int'(ins[25:21]);
    t   = int'(ins[20:16]);
    erd = int'(ins[15:11]);
    sh  = int'(ins[10:6]);
    imm = int'(ins[7:0]);
    a   = mdl[s];
    b   = mdl[t];
    sa  = (a > 127) ? a - 256 : a;
    sb  = (b > 127) ? b - 256 : b;
    einv  = 1'b0;
    ehalt = 1'b0;
    r     = 0;
    if (opc == 'h3F) ehalt = 1'b1;
    else if (opc == 'h08) begin erd = t; r = (a + imm) % 256; end
    else if (opc == 'h0D) begin erd = t; r = a | imm; end
    else if (opc == 0 && fn == 'h20) r = (a + b) % 256;
    else if (opc == 0 && fn == 'h22) r = (a - b + 256) % 256;
    else if (opc == 0 && fn == 'h24) r = a & b;
    else if (opc == 0 && fn == 'h25) r = a | b;
    else if (opc == 0 && fn == 'h2A) r = (sa < sb) ? 1 : 0;
    else if (opc == 0 && fn == 'h00 && SHIFT_EN)
      r = (sh >= 8) ? 0 : (b * (1 << sh)) % 256;
    else if (opc == 0 && fn == 'h02 && SHIFT_EN)
      r = (sh >= 8) ? 0 : b / (1 << sh);
    else einv = 1'b1;
    eres = einv ? 0 : r;
  endtask

  task automatic run_instr(input logic [31:0] ins);
    int erd, eres, n;
    bit einv, ehalt;
    model(ins, erd, einv, eres, ehalt);
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      chk("req_wait", 32'(bus.imem_req), 1);
      return;
    end
    chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_pc));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.imem_valid = 1'b1;
    bus.imem_data  = ins;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    chk("st_decode", 32'(state), 32'(STATE_DECODE));
    @(negedge clk);
    if (ehalt) begin
      chk("st_output", 32'(state), 32'(STATE_OUTPUT));
      return;
    end
    chk("st_rf", 32'(state), 32'(STATE_RF));
    chk("rs", 32'(rs), 32'(ins[25:21]));
    chk("rt", 32'(rt), 32'(ins[20:16]));
    chk("invalid", 32'(instruction_invalid), 32'(einv));
    if (!einv) chk("rd", 32'(rd), 32'(erd));
    @(negedge clk);
    chk("st_ex", 32'(state), 32'(STATE_EX));
    @(negedge clk);
    chk("st_wb", 32'(state), 32'(STATE_WB));
    chk("result", 32'(result), 32'(eres));
    @(negedge clk);
    exp_pc = (exp_pc + 1) % 256;
    chk("st_fetch", 32'(state), 32'(STATE_FETCH));
    chk("pc", 32'(pc), 32'(exp_pc));
    if (!einv && erd != 0) mdl[erd] = eres;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    exp_pc = 0;
  endtask

  logic [31:0] ins;
  int          bad_ops [4] = '{'h11, 'h02, 'h23, 'h2B};

  initial begin
    rst_n          = 1'b0;
    done           = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    exp_pc = 0;

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'(STATE_FETCH));
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_rs", 32'(rs), 0);
    chk("rst_rt", 32'(rt), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_inv", 32'(instruction_invalid), 0);
    rst_n = 1'b1;

    repeat (10) @(negedge clk);
    chk("idle_state", 32'(state), 32'(STATE_FETCH));
    chk("idle_req", 32'(bus.imem_req), 1);
    chk("idle_addr", 32'(bus.imem_addr), 0);

    run_instr(itype('h08, 0, 1, 'h05));
    run_instr(itype('h08, 0, 2, 'hFE));
    run_instr(rtype(1, 2, 4, 0, 'h20));
    chk("add_wrap", 32'(result), 32'h03);
    run_instr(rtype(1, 2, 3, 0, 'h22));
    chk("sub", 32'(result), 32'h07);
    run_instr(rtype(2, 1, 3, 0, 'h2A));
    chk("slt_signed", 32'(result), 32'h01);
    run_instr(itype('h11, 1, 2, 'h1234));
    chk("inv_result", 32'(result), 0);
    run_instr(itype('h08, 0, 6, 'h81));
    run_instr(rtype(0, 6, 5, 1, 'h00));
    chk("sll1", 32'(result), SHIFT_EN ? 32'h02 : 32'h00);
    chk("sll_inv", 32'(instruction_invalid), 32'(!SHIFT_EN));
    run_instr(rtype(0, 6, 5, 9, 'h00));
    chk("sll9", 32'(result), 0);

    // Random program, long enough to wrap the 8-bit pc
    for (int k = 0; k < 250; k++) begin
      int kind, s, t, d, sh, imm;
      kind = $urandom_range(0, 10);
      s    = $urandom_range(0, 7);
      t    = $urandom_range(0, 7);
      d    = $urandom_range(0, 7);
      sh   = $urandom_range(0, 10);
      imm  = $urandom_range(0, 65535);
      unique case (kind)
        0: ins = rtype(s, t, d, sh, 'h20);
        1: ins = rtype(s, t, d, sh, 'h22);
        2: ins = rtype(s, t, d, sh, 'h24);
        3: ins = rtype(s, t, d, sh, 'h25);
        4: ins = rtype(s, t, d, sh, 'h2A);
        5: ins = itype('h08, s, t, imm);
        6: ins = itype('h0D, s, t, imm);
        7: ins = rtype(s, t, d, sh, 'h00);
        8: ins = rtype(s, t, d, sh, 'h02);
        9: ins = itype(bad_ops[$urandom_range(0, 3)], s, t, imm);
        default: ins = rtype(s, t, d, sh, 'h01);
      endcase
      run_instr(ins);
    end

    run_instr({6'h3F, 26'd0});
    chk("out_req", 32'(bus.imem_req), 0);
    repeat (3) @(negedge clk);
    chk("out_hold", 32'(state), 32'(STATE_OUTPUT));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("halt_state", 32'(state), 32'(STATE_HALT));
    bus.imem_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.imem_valid = 1'b0;
    chk("halt_stay", 32'(state), 32'(STATE_HALT));
    chk("halt_req", 32'(bus.imem_req), 0);
    chk("halt_pc", 32'(pc), 32'(exp_pc));

    do_reset();
    run_instr(itype('h08, 0, 1, 'h07));
    chk("pre_rst_pc", 32'(pc), 1);
    bus.imem_valid = 1'b1;
    bus.imem_data  = itype('h08, 0, 2, 'h09);
    rst_n          = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", 32'(state), 32'(STATE_FETCH));
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_req", 32'(bus.imem_req), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("stale_valid", 32'(state), 32'(STATE_FETCH));
    chk("req_reissue", 32'(bus.imem_req), 1);
    bus.imem_valid = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    exp_pc = 0;
    run_instr(itype('h0D, 0, 3, 'h5A));
    chk("post_rst", 32'(result), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
